// File: rtl/dmem_lsu_sequencer.sv
// Load/store sequencer between the RV32I datapath and a byte-wide data memory.
// Each request is split into 1, 2 or 4 little-endian byte accesses, one per
// cycle. Load bytes are assembled and then sign- or zero-extended. Illegal or
// misaligned requests complete with an error and do not touch memory.
// The memory-side and response outputs are registers computed from the
// next-state values, so they change only on a clock edge or on reset.
module dmem_lsu_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int XLEN       = 32
) (
  input  logic                  Clk,
  input  logic                  n_Rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  busy,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [7:0]            mem_wd,
  input  logic [7:0]            mem_rd
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  // funct3 encodings that exist for the given direction
  function automatic logic req_legal(input logic we, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b100, 3'b101:         return ~we;
      default:                return 1'b0;
    endcase
  endfunction

  // halfwords need addr[0]=0, words need addr[1:0]=00
  function automatic logic req_aligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return ~a[0];
      2'b10:   return (a == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  // index of the final byte of the access (N-1)
  function automatic logic [1:0] last_idx(input logic [2:0] f3);
    case (f3[1:0])
      2'b01:   return 2'd1;
      2'b10:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // little-endian byte lane k of a word
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // size/sign extension of the assembled load bytes
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  return {{24{a[7]}}, a[7:0]};
      3'b001:  return {{16{a[15]}}, a[15:0]};
      3'b100:  return {24'h000000, a[7:0]};
      3'b101:  return {16'h0000, a[15:0]};
      default: return a;
    endcase
  endfunction

  state_t                state_r, state_n;
  logic [1:0]            cnt_r, cnt_n;
  logic                  we_r, we_n;
  logic [2:0]            f3_r, f3_n;
  logic [ADDR_WIDTH-1:0] addr_r, addr_n;
  logic [XLEN-1:0]       wdata_r, wdata_n;
  logic [XLEN-1:0]       asm_r, asm_n;
  logic                  err_r, err_n;
  logic                  resp_valid_n, resp_err_n, mem_we_n;
  logic [XLEN-1:0]       resp_rdata_n;
  logic [ADDR_WIDTH-1:0] mem_a_n;
  logic [7:0]            mem_wd_n;

  assign req_ready = (state_r == IDLE);
  assign busy      = (state_r != IDLE);

  // next-state, request capture, load assembly and next output values
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    we_n    = we_r;
    f3_n    = f3_r;
    addr_n  = addr_r;
    wdata_n = wdata_r;
    asm_n   = asm_r;
    err_n   = err_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          we_n    = req_we;
          f3_n    = req_funct3;
          addr_n  = req_addr;
          wdata_n = req_wdata;
          cnt_n   = 2'd0;
          asm_n   = '0;
          if (req_legal(req_we, req_funct3) && req_aligned(req_funct3, req_addr[1:0])) begin
            err_n   = 1'b0;
            state_n = ACCESS;
          end else begin
            err_n   = 1'b1;
            state_n = DONE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      ACCESS: begin
        if (!we_r) begin
          case (cnt_r)
            2'd0:    asm_n[7:0]   = mem_rd;
            2'd1:    asm_n[15:8]  = mem_rd;
            2'd2:    asm_n[23:16] = mem_rd;
            default: asm_n[31:24] = mem_rd;
          endcase
        end else begin
          asm_n = asm_r;
        end
        if (cnt_r == last_idx(f3_r)) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt_r + 2'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    mem_we_n = (state_n == ACCESS) && we_n;
    if (state_n == ACCESS) begin
      mem_a_n = addr_n + ADDR_WIDTH'(cnt_n);
    end else begin
      mem_a_n = '0;
    end
    if (mem_we_n) begin
      mem_wd_n = byte_sel(wdata_n, cnt_n);
    end else begin
      mem_wd_n = 8'h00;
    end
    resp_valid_n = (state_n == DONE);
    resp_err_n   = (state_n == DONE) && err_n;
    if ((state_n == DONE) && !err_n && !we_n) begin
      resp_rdata_n = load_extend(f3_n, asm_n);
    end else begin
      resp_rdata_n = '0;
    end
  end

  // state, captured request and registered outputs; reset aborts any access
  always_ff @(posedge Clk or negedge n_Rst) begin
    if (!n_Rst) begin
      state_r    <= IDLE;
      cnt_r      <= 2'd0;
      we_r       <= 1'b0;
      f3_r       <= 3'b000;
      addr_r     <= '0;
      wdata_r    <= '0;
      asm_r      <= '0;
      err_r      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_a      <= '0;
      mem_wd     <= 8'h00;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      we_r       <= we_n;
      f3_r       <= f3_n;
      addr_r     <= addr_n;
      wdata_r    <= wdata_n;
      asm_r      <= asm_n;
      err_r      <= err_n;
      resp_valid <= resp_valid_n;
      resp_err   <= resp_err_n;
      resp_rdata <= resp_rdata_n;
      mem_we     <= mem_we_n;
      mem_a      <= mem_a_n;
      mem_wd     <= mem_wd_n;
    end
  end

endmodule

// File: tb/tb_dmem_lsu_sequencer.sv
// Scoreboard bench for dmem_lsu_sequencer: a byte-array memory model, a
// request driver with a reference model, and an independent response monitor.
module tb_dmem_lsu_sequencer;

  logic        Clk = 1'b0;
  logic        n_Rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid, resp_err, busy, mem_we;
  logic [31:0] resp_rdata;
  logic [7:0]  mem_a, mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_seen = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    int          wes;
  } exp_t;
  exp_t q[$];

  logic [7:0] mem [0:255];
  logic [7:0] ref_mem [0:255];

  dmem_lsu_sequencer #(.ADDR_WIDTH(8), .XLEN(32)) dut (
    .Clk(Clk), .n_Rst(n_Rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .busy(busy), .mem_we(mem_we), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 Clk = ~Clk;

  // cycle counter for latency checks
  always @(posedge Clk) cyc <= cyc + 1;

  // data memory: combinational read, write on rising edge
  assign mem_rd = mem[mem_a];
  always @(posedge Clk) if (mem_we) mem[mem_a] <= mem_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: decides outcome from the instruction rules, updates ref_mem
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [7:0] addr, input logic [31:0] wd, input int now);
    exp_t e;
    int n;
    bit legal, aligned;
    logic [31:0] v;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    aligned = (addr % n) == 0;
    e.err = !(legal && aligned);
    e.rdata = 32'h0;
    e.wes = 0;
    e.cyc = now + (e.err ? 1 : n + 1);
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[addr + i] = 8'((wd >> (8 * i)) & 32'hFF);
        e.wes = n;
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v + (32'(ref_mem[addr + i]) << (8 * i));
        if (f3 == 3'd0 && v >= 32'd128)   v = v + 32'hFFFFFF00;
        if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF0000;
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // present a request (called at a negedge); returns at the negedge after acceptance
  task automatic issue(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                       input logic [31:0] wd);
    int t;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge Clk);
      t++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      q.push_back(model(we, f3, addr, wd, cyc));
      @(negedge Clk);
    end
  endtask

  task automatic drain();
    int t;
    req_valid = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 20) begin
      @(negedge Clk);
      t++;
    end
    chk("drain_pending", 32'(q.size()), 32'd0);
    @(negedge Clk);
  endtask

  // response monitor: pops the scoreboard on every resp_valid
  always @(negedge Clk) begin
    exp_t e;
    if (n_Rst) begin
      if (mem_we) we_seen++;
      chk("ready_vs_busy", {31'd0, req_ready}, {31'd0, ~busy});
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_latency", 32'(cyc), 32'(e.cyc));
          chk("mem_we_cycles", 32'(we_seen), 32'(e.wes));
        end
        we_seen = 0;
      end
    end
  end

  initial begin
    logic [2:0] f3;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    repeat (3) @(negedge Clk);
    n_Rst = 1'b1;
    @(negedge Clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mem_out", {15'd0, mem_we, mem_a, mem_wd}, 32'd0);

    // store word, then check the memory byte layout directly
    issue(1'b1, 3'b010, 8'h10, 32'hDEADBEEF);
    drain();
    chk("sw_b0", {24'd0, mem[8'h10]}, 32'hEF);
    chk("sw_b1", {24'd0, mem[8'h11]}, 32'hBE);
    chk("sw_b2", {24'd0, mem[8'h12]}, 32'hAD);
    chk("sw_b3", {24'd0, mem[8'h13]}, 32'hDE);

    // loads of every size and sign
    issue(1'b0, 3'b010, 8'h10, 32'h0);
    issue(1'b0, 3'b001, 8'h12, 32'h0);
    issue(1'b0, 3'b101, 8'h12, 32'h0);
    issue(1'b0, 3'b000, 8'h10, 32'h0);
    issue(1'b0, 3'b100, 8'h11, 32'h0);
    issue(1'b1, 3'b000, 8'h20, 32'h000000BE);
    issue(1'b0, 3'b010, 8'h20, 32'h0);
    // misaligned and illegal requests
    issue(1'b0, 3'b010, 8'h22, 32'h0);
    issue(1'b1, 3'b001, 8'h21, 32'hFFFFFFFF);
    issue(1'b0, 3'b011, 8'h10, 32'h0);
    issue(1'b1, 3'b100, 8'h24, 32'hFFFFFFFF);
    drain();
    chk("sb_neighbour", {24'd0, mem[8'h21]}, 32'h00);

    // held-valid alternating SB/LB, then random mix with occasional gaps
    for (int i = 0; i < 16; i++)
      issue(1'(i % 2 == 0), 3'b000, 8'h40 + 8'(i / 2), $urandom);
    for (int i = 0; i < 150; i++) begin
      f3 = 3'($urandom_range(0, 7));
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) f3 = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) f3 = 3'd7;
      issue(1'($urandom_range(0, 1)), f3, 8'h40 + 8'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        @(negedge Clk);
      end
    end
    drain();

    // reset in the middle of a word store, after two bytes have been written
    issue(1'b1, 3'b010, 8'h30, 32'h11223344);
    req_valid = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    chk("abort_mem_we_before", {31'd0, mem_we}, 32'd1);
    n_Rst = 1'b0;
    #1;
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    q.delete();
    ref_mem[8'h32] = 8'h00;
    ref_mem[8'h33] = 8'h00;
    @(negedge Clk);
    n_Rst = 1'b1;
    we_seen = 0;
    repeat (6) @(negedge Clk);
    chk("post_abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_b0", {24'd0, mem[8'h30]}, 32'h44);
    chk("abort_b1", {24'd0, mem[8'h31]}, 32'h33);
    chk("abort_b2", {24'd0, mem[8'h32]}, 32'h00);
    chk("abort_b3", {24'd0, mem[8'h33]}, 32'h00);
    for (int i = 0; i < 256; i++)
      chk($sformatf("mem_%0h", i), {24'd0, mem[i]}, {24'd0, ref_mem[i]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
